// File: rtl/dcm_rst_seq.sv
// dcm_rst_seq: clock/reset sequencer for the on-chip DCM.
// Pulses the DCM reset, waits for a filtered LOCKED with a timeout, requires
// a run of stable lock cycles, and only then releases the active-low system
// reset. Failed attempts are retried up to MAX_RETRY times before a sticky
// fail flag is raised. Clocked by the free-running reference (DCM CLKIN).
module dcm_rst_seq #(
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int LOCK_STABLE    = 16,
  parameter int MAX_RETRY      = 3,
  parameter int RETRY_W        = 2,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               locked_in,
  input  logic               restart,
  output logic               dcm_rst,
  output logic               sys_reset_,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [2:0]         state
);

  // State encodings (visible on the state output)
  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_DCM_RST   = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_STABLE    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle phase is seen with cnt == N-1.
  localparam logic [CNT_W-1:0]   C_RST_LAST = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   C_STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   C_CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
  localparam logic [RETRY_W-1:0] C_RTY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] C_RTY_ZERO = RETRY_W'(0);
  localparam logic [RETRY_W-1:0] C_RTY_ONE  = RETRY_W'(1);

  // Lock synchroniser
  logic               r_sync1;
  logic               r_sync2;
  logic               w_locked_s;

  // FSM state, shared cycle counter and registered outputs
  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_dcm_rst;
  logic               r_sys_rst_n;
  logic               r_fail;

  // Next-state / next-output nets
  logic [2:0]         w_nxt_state;
  logic [RETRY_W-1:0] w_nxt_retry;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic               w_nxt_dcm_rst;
  logic               w_nxt_sys_rst_n;
  logic               w_nxt_fail;
  logic               w_restart_hit;
  logic               w_attempt_fail;
  logic               w_timed_state;

  assign w_locked_s = r_sync2;

  // Two-flop synchroniser for the asynchronous DCM LOCKED status
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked_in;
      r_sync2 <= r_sync1;
    end
  end

  // State register: state, counter, retry count and outputs update together
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ST_RESET;
      r_cnt       <= C_CNT_ZERO;
      r_retry     <= C_RTY_ZERO;
      r_dcm_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_retry     <= w_nxt_retry;
      r_dcm_rst   <= w_nxt_dcm_rst;
      r_sys_rst_n <= w_nxt_sys_rst_n;
      r_fail      <= w_nxt_fail;
    end
  end

  // Next-state logic: restart overrides everything except the RESET state
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_retry    = r_retry;
    w_attempt_fail = 1'b0;
    w_restart_hit  = restart && (r_state != ST_RESET);

    if (w_restart_hit) begin
      w_nxt_state = ST_DCM_RST;
      w_nxt_retry = C_RTY_ZERO;
    end else begin
      case (r_state)
        ST_RESET: begin
          w_nxt_state = ST_DCM_RST;
        end
        ST_DCM_RST: begin
          if (r_cnt == C_RST_LAST) begin
            w_nxt_state = ST_WAIT_LOCK;
          end else begin
            w_nxt_state = ST_DCM_RST;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_nxt_state = ST_STABLE;
          end else if (r_cnt == C_TO_LAST) begin
            w_attempt_fail = 1'b1;
          end else begin
            w_nxt_state = ST_WAIT_LOCK;
          end
        end
        ST_STABLE: begin
          // Any dropout during the stability window aborts the attempt
          if (!w_locked_s) begin
            w_attempt_fail = 1'b1;
          end else if (r_cnt == C_STB_LAST) begin
            w_nxt_state = ST_RUN;
            w_nxt_retry = C_RTY_ZERO;
          end else begin
            w_nxt_state = ST_STABLE;
          end
        end
        ST_RUN: begin
          // Lock loss while running restarts cleanly; not a failed attempt
          if (!w_locked_s) begin
            w_nxt_state = ST_DCM_RST;
            w_nxt_retry = C_RTY_ZERO;
          end else begin
            w_nxt_state = ST_RUN;
          end
        end
        ST_FAIL: begin
          w_nxt_state = ST_FAIL;
        end
        default: begin
          // Unused encodings recover through a fresh DCM reset
          w_nxt_state = ST_DCM_RST;
          w_nxt_retry = C_RTY_ZERO;
        end
      endcase

      if (w_attempt_fail) begin
        if (r_retry == C_RTY_MAX) begin
          w_nxt_state = ST_FAIL;
        end else begin
          w_nxt_state = ST_DCM_RST;
          w_nxt_retry = r_retry + C_RTY_ONE;
        end
      end else begin
        w_nxt_retry = w_nxt_retry;
      end
    end
  end

  // Output logic: next registered outputs derived from the next state
  always_comb begin
    w_nxt_dcm_rst   = 1'b1;
    w_nxt_sys_rst_n = 1'b0;
    w_nxt_fail      = 1'b0;
    w_timed_state   = 1'b0;

    case (w_nxt_state)
      ST_RESET: begin
        w_nxt_dcm_rst = 1'b1;
      end
      ST_DCM_RST: begin
        w_nxt_dcm_rst = 1'b1;
        w_timed_state = 1'b1;
      end
      ST_WAIT_LOCK: begin
        w_nxt_dcm_rst = 1'b0;
        w_timed_state = 1'b1;
      end
      ST_STABLE: begin
        w_nxt_dcm_rst = 1'b0;
        w_timed_state = 1'b1;
      end
      ST_RUN: begin
        w_nxt_dcm_rst   = 1'b0;
        w_nxt_sys_rst_n = 1'b1;
      end
      ST_FAIL: begin
        w_nxt_dcm_rst = 1'b1;
        w_nxt_fail    = 1'b1;
      end
      default: begin
        w_nxt_dcm_rst = 1'b1;
      end
    endcase

    // Counter restarts on every state change and on a (held) restart;
    // it only runs in the timed phases so it never wraps in RUN/FAIL.
    if ((w_nxt_state != r_state) || w_restart_hit) begin
      w_nxt_cnt = C_CNT_ZERO;
    end else if (w_timed_state) begin
      w_nxt_cnt = r_cnt + C_CNT_ONE;
    end else begin
      w_nxt_cnt = C_CNT_ZERO;
    end
  end

  assign dcm_rst    = r_dcm_rst;
  assign sys_reset_ = r_sys_rst_n;
  assign fail       = r_fail;
  assign retry_cnt  = r_retry;
  assign state      = r_state;

endmodule

// File: tb/tb_dcm_rst_seq.sv
// tb_dcm_rst_seq: directed bench for dcm_rst_seq with default parameters.
// Edge numbers count rising clock edges after reset_ is released.
module tb_dcm_rst_seq;

  logic       clk;
  logic       reset_;
  logic       locked_in;
  logic       restart;
  logic       dcm_rst;
  logic       sys_reset_;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int n_checks;
  int n_fail;
  int edge_no;

  typedef struct {
    bit         do_rst;
    bit         locked;
    int         at_edge;
    logic       exp_dcm;
    logic       exp_sys;
    logic       exp_fail;
    logic [1:0] exp_retry;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs [17];

  dcm_rst_seq dut (
    .clk        (clk),
    .reset_     (reset_),
    .locked_in  (locked_in),
    .restart    (restart),
    .dcm_rst    (dcm_rst),
    .sys_reset_ (sys_reset_),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d: got %0d expected %0d", nm, edge_no, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic d, input logic s, input logic f,
                         input logic [1:0] r, input logic [2:0] st);
    chk({tag, ".dcm_rst"},    {31'd0, dcm_rst},    {31'd0, d});
    chk({tag, ".sys_reset_"}, {31'd0, sys_reset_}, {31'd0, s});
    chk({tag, ".fail"},       {31'd0, fail},       {31'd0, f});
    chk({tag, ".retry_cnt"},  {30'd0, retry_cnt},  {30'd0, r});
    chk({tag, ".state"},      {29'd0, state},      {29'd0, st});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic adv_to(input int target);
    while (edge_no < target) step();
  endtask

  // Hold reset_, check reset values, release between edges
  task automatic do_reset(input bit lk);
    reset_    = 1'b0;
    locked_in = lk;
    restart   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
    @(negedge clk);
    reset_  = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    int b;
    n_checks  = 0;
    n_fail    = 0;
    edge_no   = 0;
    reset_    = 1'b0;
    locked_in = 1'b0;
    restart   = 1'b0;

    // T1: locked stuck high -> RUN at edge 22
    vecs[0]  = '{1'b1, 1'b1,    1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1};
    vecs[1]  = '{1'b0, 1'b1,    4, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1};
    vecs[2]  = '{1'b0, 1'b1,    5, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2};
    vecs[3]  = '{1'b0, 1'b1,    6, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3};
    vecs[4]  = '{1'b0, 1'b1,   21, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3};
    vecs[5]  = '{1'b0, 1'b1,   22, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4};
    // T2: locked stuck low -> four timed-out attempts, FAIL at edge 4113
    vecs[6]  = '{1'b1, 1'b0,    1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1};
    vecs[7]  = '{1'b0, 1'b0,    5, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2};
    vecs[8]  = '{1'b0, 1'b0, 1028, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2};
    vecs[9]  = '{1'b0, 1'b0, 1029, 1'b1, 1'b0, 1'b0, 2'd1, 3'd1};
    vecs[10] = '{1'b0, 1'b0, 1032, 1'b1, 1'b0, 1'b0, 2'd1, 3'd1};
    vecs[11] = '{1'b0, 1'b0, 1033, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2};
    vecs[12] = '{1'b0, 1'b0, 2057, 1'b1, 1'b0, 1'b0, 2'd2, 3'd1};
    vecs[13] = '{1'b0, 1'b0, 3085, 1'b1, 1'b0, 1'b0, 2'd3, 3'd1};
    vecs[14] = '{1'b0, 1'b0, 4112, 1'b0, 1'b0, 1'b0, 2'd3, 3'd2};
    vecs[15] = '{1'b0, 1'b0, 4113, 1'b1, 1'b0, 1'b1, 2'd3, 3'd5};
    vecs[16] = '{1'b0, 1'b0, 4200, 1'b1, 1'b0, 1'b1, 2'd3, 3'd5};

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].do_rst) do_reset(vecs[i].locked);
      locked_in = vecs[i].locked;
      adv_to(vecs[i].at_edge);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_dcm, vecs[i].exp_sys,
              vecs[i].exp_fail, vecs[i].exp_retry, vecs[i].exp_state);
    end

    // T5: FAIL holds without restart, then a 1-cycle restart recovers
    locked_in = 1'b1;
    b = edge_no;
    adv_to(b + 3);
    chk_all("t5_hold", 1'b1, 1'b0, 1'b1, 2'd3, 3'd5);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk_all("t5_restart", 1'b1, 1'b0, 1'b0, 2'd0, 3'd1);
    b = edge_no;
    adv_to(b + 20);
    chk_all("t5_pre_run", 1'b0, 1'b0, 1'b0, 2'd0, 3'd3);
    step();
    chk_all("t5_run", 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);

    // Held restart keeps the sequencer parked in DCM_RST
    restart = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_all("held_restart", 1'b1, 1'b0, 1'b0, 2'd0, 3'd1);
    end
    restart = 1'b0;
    b = edge_no;
    adv_to(b + 20);
    chk_all("held_pre_run", 1'b0, 1'b0, 1'b0, 2'd0, 3'd3);
    step();
    chk_all("held_run", 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);

    // T3: one-cycle lock drop in RUN restarts the sequence
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    step();
    chk_all("t3_sync_lat", 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);
    step();
    chk_all("t3_drop", 1'b1, 1'b0, 1'b0, 2'd0, 3'd1);
    b = edge_no;
    adv_to(b + 20);
    chk_all("t3_pre_run", 1'b0, 1'b0, 1'b0, 2'd0, 3'd3);
    step();
    chk_all("t3_run", 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);

    // T4: glitch seen by the FSM at STABLE cnt=8 (edge 15)
    do_reset(1'b1);
    adv_to(12);
    locked_in = 1'b0;
    step();
    locked_in = 1'b1;
    step();
    chk_all("t4_stable", 1'b0, 1'b0, 1'b0, 2'd0, 3'd3);
    step();
    chk_all("t4_fail", 1'b1, 1'b0, 1'b0, 2'd1, 3'd1);
    while (edge_no < 35) begin
      step();
      chk("t4_no_sys_pulse", {31'd0, sys_reset_}, 32'd0);
    end
    step();
    chk_all("t4_run", 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);

    // T6: asynchronous reset_ mid-WAIT_LOCK
    do_reset(1'b0);
    adv_to(100);
    chk_all("t6_wait", 1'b0, 1'b0, 1'b0, 2'd0, 3'd2);
    #3;
    reset_ = 1'b0;
    #1;
    chk_all("t6_async", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
    @(negedge clk);
    reset_  = 1'b1;
    edge_no = 0;
    adv_to(1100);
    chk_all("t6_wait_retry", 1'b0, 1'b0, 1'b0, 2'd1, 3'd2);
    #3;
    reset_ = 1'b0;
    #1;
    chk_all("t6_async_retry", 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
